// File: rtl/axi_dma_pkg.sv
// axi_dma_pkg: state encodings and constants shared by the DMA copy controller.
package axi_dma_pkg;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_WAIT} wr_state_t;
  localparam int BUS_WIDTH = 32;
  localparam int PAGE_BYTES = 4096;
  localparam int BYTES_PER_BEAT = BUS_WIDTH / 8;
endpackage

// File: rtl/axi_dma_burst_calc.sv
// axi_dma_burst_calc: beats of the next burst, capped by remaining words, MAX_BEATS and the 4 KB page end.
module axi_dma_burst_calc
  import axi_dma_pkg::*;
#(
  parameter int LEN_WIDTH = 16,
  parameter int MAX_BEATS = 16,
  parameter int PO_WIDTH  = $clog2(PAGE_BYTES)
) (
  input  logic [PO_WIDTH-1:0]  addr,
  input  logic [LEN_WIDTH-1:0] rem,
  output logic [LEN_WIDTH-1:0] beats
);
  logic [31:0] page_beats, cap;
  always_comb begin
    page_beats = (32'(PAGE_BYTES) - 32'(addr)) >> $clog2(BYTES_PER_BEAT);
    cap = page_beats < 32'(MAX_BEATS) ? page_beats : 32'(MAX_BEATS);
    beats = 32'(rem) < cap ? rem : LEN_WIDTH'(cap);
  end
endmodule

// File: rtl/axi_dma_copy_ctrl.sv
// axi_dma_copy_ctrl: memory-to-memory copy engine driving axi_master; independent read and
// write burst FSMs coupled by a credit of words already pushed into the sink FIFO.
module axi_dma_copy_ctrl
  import axi_dma_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int BURST_LEN_WIDTH = 8,
  parameter int MAX_BEATS       = 16,
  parameter int LEN_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       copy_start,
  input  logic [ADDR_WIDTH-1:0]      copy_src_addr,
  input  logic [ADDR_WIDTH-1:0]      copy_dst_addr,
  input  logic [LEN_WIDTH-1:0]       copy_words,
  output logic                       copy_busy,
  output logic                       copy_done,
  output logic                       start_read,
  output logic [ADDR_WIDTH-1:0]      target_read_addr,
  output logic [BURST_LEN_WIDTH-1:0] target_read_burst_len,
  input  logic                       done_read,
  output logic                       start_write,
  output logic [ADDR_WIDTH-1:0]      target_write_addr,
  output logic [BURST_LEN_WIDTH-1:0] target_write_burst_len,
  input  logic                       done_write,
  input  logic [DATA_WIDTH-1:0]      m2d_rdata,
  input  logic                       m2d_rempty,
  output logic                       m2d_rpull,
  output logic [DATA_WIDTH-1:0]      d2m_wdata,
  output logic                       d2m_wpush,
  input  logic                       d2m_wfull
);
  localparam int PO = $clog2(PAGE_BYTES);
  rd_state_t rd_state, rd_next;
  wr_state_t wr_state, wr_next;
  logic [ADDR_WIDTH-1:0] rd_addr, wr_addr;
  logic [LEN_WIDTH-1:0] rd_rem, wr_rem, cp_rem, rd_beats, wr_beats;
  logic [LEN_WIDTH:0] credit;
  logic xfer, finish;

  axi_dma_burst_calc #(.LEN_WIDTH(LEN_WIDTH), .MAX_BEATS(MAX_BEATS)) rd_calc (
    .addr(rd_addr[PO-1:0]), .rem(rd_rem), .beats(rd_beats));
  axi_dma_burst_calc #(.LEN_WIDTH(LEN_WIDTH), .MAX_BEATS(MAX_BEATS)) wr_calc (
    .addr(wr_addr[PO-1:0]), .rem(wr_rem), .beats(wr_beats));

  assign xfer = copy_busy && !m2d_rempty && !d2m_wfull && cp_rem != '0;
  assign m2d_rpull = xfer;
  assign d2m_wpush = xfer;
  assign d2m_wdata = m2d_rdata;
  // Idle with nothing left to write only happens for a zero-word job
  assign finish = copy_busy && wr_rem == '0 &&
                  (wr_state == W_IDLE || (wr_state == W_WAIT && done_write));

  always_comb begin
    rd_next = rd_state;
    wr_next = wr_state;
    case (rd_state)
      R_IDLE:  rd_next = copy_busy && rd_rem != '0 ? R_ISSUE : R_IDLE;
      R_ISSUE: rd_next = R_WAIT;
      R_WAIT:  rd_next = !done_read ? R_WAIT : rd_rem != '0 ? R_ISSUE : R_IDLE;
      default: rd_next = R_IDLE;
    endcase
    case (wr_state)
      W_IDLE:  wr_next = copy_busy && wr_rem != '0 && credit >= {1'b0, wr_beats} ? W_ISSUE : W_IDLE;
      W_ISSUE: wr_next = W_WAIT;
      W_WAIT:  wr_next = done_write ? W_IDLE : W_WAIT;
      default: wr_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= R_IDLE;
      wr_state <= W_IDLE;
    end else begin
      rd_state <= rd_next;
      wr_state <= wr_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      copy_busy <= 1'b0;
      copy_done <= 1'b0;
      start_read <= 1'b0;
      start_write <= 1'b0;
      target_read_addr <= '0;
      target_read_burst_len <= '0;
      target_write_addr <= '0;
      target_write_burst_len <= '0;
      rd_addr <= '0;
      wr_addr <= '0;
      rd_rem <= '0;
      wr_rem <= '0;
      cp_rem <= '0;
      credit <= '0;
    end else begin
      start_read <= rd_state == R_ISSUE;
      start_write <= wr_state == W_ISSUE;
      copy_done <= finish;
      credit <= credit + {{LEN_WIDTH{1'b0}}, xfer} - (wr_state == W_ISSUE ? {1'b0, wr_beats} : '0);
      if (xfer) cp_rem <= cp_rem - LEN_WIDTH'(1);
      if (finish) copy_busy <= 1'b0;
      else if (copy_start && !copy_busy) begin
        copy_busy <= 1'b1;
        rd_addr <= copy_src_addr;
        wr_addr <= copy_dst_addr;
        rd_rem <= copy_words;
        wr_rem <= copy_words;
        cp_rem <= copy_words;
      end
      if (rd_state == R_ISSUE) begin
        target_read_addr <= rd_addr;
        target_read_burst_len <= BURST_LEN_WIDTH'(rd_beats - LEN_WIDTH'(1));
        rd_addr <= rd_addr + (ADDR_WIDTH'(rd_beats) << $clog2(BYTES_PER_BEAT));
        rd_rem <= rd_rem - rd_beats;
      end
      if (wr_state == W_ISSUE) begin
        target_write_addr <= wr_addr;
        target_write_burst_len <= BURST_LEN_WIDTH'(wr_beats - LEN_WIDTH'(1));
        wr_addr <= wr_addr + (ADDR_WIDTH'(wr_beats) << $clog2(BYTES_PER_BEAT));
        wr_rem <= wr_rem - wr_beats;
      end
    end
  end
endmodule

// File: tb/tb_axi_dma_copy_ctrl.sv
// tb_axi_dma_copy_ctrl: axi_master/FIFO environment with a burst-plan model of the copy controller.
module tb_axi_dma_copy_ctrl;
  localparam int AW = 32, DW = 32, BW = 8, MB = 16, LW = 16;
  logic clk = 0, rst_n = 0, copy_start = 0, done_read = 0, done_write = 0;
  logic [AW-1:0] copy_src_addr = 0, copy_dst_addr = 0;
  logic [LW-1:0] copy_words = 0;
  logic copy_busy, copy_done, start_read, start_write, m2d_rpull, d2m_wpush;
  logic [AW-1:0] target_read_addr, target_write_addr;
  logic [BW-1:0] target_read_burst_len, target_write_burst_len;
  logic [DW-1:0] m2d_rdata = 0, d2m_wdata;
  logic m2d_rempty = 1, d2m_wfull = 0, force_full = 0;

  axi_dma_copy_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN_WIDTH(BW), .MAX_BEATS(MB), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .copy_start(copy_start), .copy_src_addr(copy_src_addr),
    .copy_dst_addr(copy_dst_addr), .copy_words(copy_words), .copy_busy(copy_busy), .copy_done(copy_done),
    .start_read(start_read), .target_read_addr(target_read_addr), .target_read_burst_len(target_read_burst_len),
    .done_read(done_read), .start_write(start_write), .target_write_addr(target_write_addr),
    .target_write_burst_len(target_write_burst_len), .done_write(done_write), .m2d_rdata(m2d_rdata),
    .m2d_rempty(m2d_rempty), .m2d_rpull(m2d_rpull), .d2m_wdata(d2m_wdata), .d2m_wpush(d2m_wpush),
    .d2m_wfull(d2m_wfull));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  logic [DW-1:0] m2d_q[$], d2m_q[$];
  logic [AW-1:0] exp_ra[$], exp_wa[$], rd_pa[$], wr_pa[$];
  int exp_rl[$], exp_wl[$], rd_pl[$], wr_pl[$];
  logic [AW-1:0] job_src = 0, job_dst = 0, re_addr = 0, we_addr = 0;
  int job_words = 0, copied = 0, written = 0, pushed = 0, wr_issued = 0, done_cd = 0, re_cnt = 0, we_cnt = 0;
  logic s_pull = 0, s_push = 0, s_sr = 0, s_sw = 0;
  logic [AW-1:0] s_ra = 0, s_wa = 0;
  logic [BW-1:0] s_rl = 0, s_wl = 0;
  logic [DW-1:0] s_wd = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] src_word(input logic [AW-1:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5a5a_0000;
  endfunction

  function automatic int beats_for(input logic [AW-1:0] a, input int rem);
    int page;
    page = (4096 - int'(a % 4096)) / 4;
    return (rem < MB && rem < page) ? rem : (MB < page ? MB : page);
  endfunction

  task automatic plan(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n);
    logic [AW-1:0] a;
    int r, b;
    exp_ra.delete(); exp_rl.delete(); exp_wa.delete(); exp_wl.delete();
    job_src = s; job_dst = d; job_words = n;
    copied = 0; written = 0; pushed = 0; wr_issued = 0;
    a = s; r = n;
    while (r > 0) begin
      b = beats_for(a, r);
      exp_ra.push_back(a); exp_rl.push_back(b - 1);
      a = a + 32'(b * 4); r -= b;
    end
    a = d; r = n;
    while (r > 0) begin
      b = beats_for(a, r);
      exp_wa.push_back(a); exp_wl.push_back(b - 1);
      a = a + 32'(b * 4); r -= b;
    end
  endtask

  task automatic clear_env();
    m2d_q.delete(); d2m_q.delete(); rd_pa.delete(); rd_pl.delete(); wr_pa.delete(); wr_pl.delete();
    exp_ra.delete(); exp_rl.delete(); exp_wa.delete(); exp_wl.delete();
    re_cnt = 0; we_cnt = 0; done_cd = 0; done_read = 0; done_write = 0;
    s_pull = 0; s_push = 0; s_sr = 0; s_sw = 0;
    m2d_rempty = 1; m2d_rdata = 0; d2m_wfull = force_full;
  endtask

  // axi_master and FIFO behaviour: serves issued bursts one beat per cycle
  task automatic serve();
    if (s_pull) void'(m2d_q.pop_front());
    if (s_push) d2m_q.push_back(s_wd);
    if (s_sr) begin rd_pa.push_back(s_ra); rd_pl.push_back(int'(s_rl)); end
    if (s_sw) begin wr_pa.push_back(s_wa); wr_pl.push_back(int'(s_wl)); end
    done_read = 0;
    done_write = 0;
    if (re_cnt > 0) begin
      m2d_q.push_back(src_word(re_addr));
      re_addr = re_addr + 4;
      re_cnt--;
      done_read = re_cnt == 0;
    end else if (rd_pa.size() > 0) begin
      re_addr = rd_pa.pop_front();
      re_cnt = rd_pl.pop_front() + 1;
    end
    if (we_cnt > 0) begin
      if (d2m_q.size() > 0) begin
        chk("wr_data", d2m_q.pop_front(), src_word(job_src + (we_addr - job_dst)));
        we_addr = we_addr + 4;
        we_cnt--;
        written++;
        if (we_cnt == 0) begin
          done_write = 1;
          if (written == job_words) done_cd = 2;
        end
      end
    end else if (wr_pa.size() > 0) begin
      we_addr = wr_pa.pop_front();
      we_cnt = wr_pl.pop_front() + 1;
    end
    m2d_rempty = m2d_q.size() == 0;
    m2d_rdata = m2d_rempty ? '0 : m2d_q[0];
    d2m_wfull = force_full || d2m_q.size() >= MB;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) clear_env();
      else begin
        s_pull = m2d_rpull; s_push = d2m_wpush; s_wd = d2m_wdata;
        s_sr = start_read; s_ra = target_read_addr; s_rl = target_read_burst_len;
        s_sw = start_write; s_wa = target_write_addr; s_wl = target_write_burst_len;
        chk("pull_eq_push", 32'(s_pull), 32'(s_push));
        if (m2d_rempty || d2m_wfull) chk("pull_blocked", 32'(s_pull), 0);
        if (s_push) begin
          chk("push_data", s_wd, src_word(job_src + 32'(4 * copied)));
          copied++; pushed++;
        end
        if (s_pull || s_sr || s_sw) chk("busy_active", 32'(copy_busy), 1);
        if (s_sr) begin
          if (exp_ra.size() == 0) chk("rd_unexpected", 1, 0);
          else begin
            chk("rd_addr", s_ra, exp_ra.pop_front());
            chk("rd_len", 32'(s_rl), exp_rl.pop_front());
          end
        end
        if (s_sw) begin
          if (exp_wa.size() == 0) chk("wr_unexpected", 1, 0);
          else begin
            chk("wr_addr", s_wa, exp_wa.pop_front());
            chk("wr_len", 32'(s_wl), exp_wl.pop_front());
          end
          chk("wr_credit", 32'(wr_issued + int'(s_wl) + 1 <= pushed), 1);
          wr_issued += int'(s_wl) + 1;
        end
        chk("copy_done", 32'(copy_done), 32'(done_cd == 1));
        if (done_cd > 0) done_cd--;
      end
      @(posedge clk);
      #1;
      if (!rst_n) clear_env();
      else serve();
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n, input bit accept);
    copy_src_addr = s; copy_dst_addr = d; copy_words = LW'(n); copy_start = 1;
    if (accept) begin
      plan(s, d, n);
      if (n == 0) done_cd = 3;
    end
    tick();
    copy_start = 0;
  endtask

  task automatic wait_done(input string name);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (copy_done) break;
    end
    chk({name, "_timeout"}, 32'(i < 3000), 1);
    tick();
  endtask

  task automatic finish_job(input string name);
    chk({name, "_busy_end"}, 32'(copy_busy), 0);
    chk({name, "_rd_left"}, exp_ra.size(), 0);
    chk({name, "_wr_left"}, exp_wa.size(), 0);
    chk({name, "_copied"}, copied, job_words);
    chk({name, "_written"}, written, job_words);
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_ctl"}, 32'({copy_busy, copy_done, start_read, start_write, m2d_rpull, d2m_wpush}), 0);
    chk({name, "_rd"}, target_read_addr | 32'(target_read_burst_len), 0);
    chk({name, "_wr"}, target_write_addr | 32'(target_write_burst_len), 0);
  endtask

  initial begin
    int i;
    #2;
    chk_reset("reset");
    tick(2);
    rst_n = 1;
    tick(2);

    start_copy(32'h1000, 32'h2000, 16, 1);
    chk("t1_busy", 32'(copy_busy), 1);
    chk("t1_rd_addr_pin", exp_ra[0], 32'h1000);
    chk("t1_rd_len_pin", exp_rl[0], 15);
    chk("t1_wr_addr_pin", exp_wa[0], 32'h2000);
    wait_done("t1");
    finish_job("t1");

    start_copy(32'h1000, 32'h2000, 40, 1);
    chk("t2_nrd_pin", exp_ra.size(), 3);
    chk("t2_rd_pin", exp_ra[2], 32'h1080);
    chk("t2_rl_pin", exp_rl[0] * 10000 + exp_rl[1] * 100 + exp_rl[2], 151507);
    chk("t2_wl_pin", exp_wl[2], 7);
    wait_done("t2");
    finish_job("t2");

    start_copy(32'h1FF8, 32'h3000, 6, 1);
    chk("t3_rd0_pin", exp_ra[0], 32'h1FF8);
    chk("t3_rd1_pin", exp_ra[1], 32'h2000);
    chk("t3_rl_pin", exp_rl[0] * 100 + exp_rl[1], 103);
    chk("t3_wr_pin", exp_wa.size() * 100 + exp_wl[0], 105);
    wait_done("t3");
    finish_job("t3");

    start_copy(32'h1000, 32'h2000, 0, 1);
    chk("t4_busy", 32'(copy_busy), 1);
    chk("t4_no_done_yet", 32'(copy_done), 0);
    wait_done("t4");
    finish_job("t4");

    start_copy(32'h4000, 32'h5000, 40, 1);
    tick(10);
    force_full = 1;
    tick();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("t5_no_pull", 32'(m2d_rpull), 0);
      tick();
    end
    force_full = 0;
    wait_done("t5");
    finish_job("t5");

    start_copy(32'h1000, 32'h2000, 40, 1);
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (start_read) break;
    end
    chk("t6_rd_seen", 32'(i < 50), 1);
    tick(2);
    rst_n = 0;
    #1;
    chk_reset("t6_async");
    tick(3);
    rst_n = 1;
    tick(2);
    chk_reset("t6_post");
    start_copy(32'h1FF8, 32'h3000, 6, 1);
    tick(3);
    start_copy(32'h8000, 32'h9000, 20, 0);
    wait_done("t6");
    finish_job("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/axi_dma_copy_ctrl.md
Name: axi_dma_copy_ctrl

Overview:
- Single-channel memory-to-memory copy engine directly upstream of axi_master.
- Splits a copy request of N 32-bit words into AXI read and write bursts, issued through axi_master's start_read/start_write control ports.
- Moves read data from the master-to-DMA FIFO into the DMA-to-master FIFO.
- Read and write sides run as two independent FSMs coupled by a word-credit counter.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, beat width; must equal the axi_master channel widths
BURST_LEN_WIDTH, 8, width of target_*_burst_len (AXI LEN encoding, beats-1)
MAX_BEATS, 16, maximum beats per burst (1..2^BURST_LEN_WIDTH)
LEN_WIDTH, 16, width of the word-count field

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
copy_start  in  1  one-cycle request; sampled only in idle
copy_src_addr  in  ADDR_WIDTH  source byte address, word aligned
copy_dst_addr  in  ADDR_WIDTH  destination byte address, word aligned
copy_words  in  LEN_WIDTH  number of words to copy
copy_busy  out  1  high from the accepted start until done
copy_done  out  1  one-cycle pulse when the last write response completes
start_read  out  1  one-cycle pulse to axi_master
target_read_addr  out  ADDR_WIDTH  burst start address
target_read_burst_len  out  BURST_LEN_WIDTH  beats-1
done_read  in  1  read burst complete
start_write  out  1  one-cycle pulse to axi_master
target_write_addr  out  ADDR_WIDTH  burst start address
target_write_burst_len  out  BURST_LEN_WIDTH  beats-1
done_write  in  1  write burst complete (after B)
m2d_rdata  in  DATA_WIDTH  show-ahead FIFO head
m2d_rempty  in  1  source FIFO empty
m2d_rpull  out  1  pop source FIFO
d2m_wdata  out  DATA_WIDTH  data to sink FIFO
d2m_wpush  out  1  push sink FIFO
d2m_wfull  in  1  sink FIFO full

Behaviour:
- Reset (asynchronous, any state): both FSMs return to IDLE; all counters clear. Outputs reset to: copy_busy=0, copy_done=0, start_read=0, start_write=0, address/len outputs=0, m2d_rpull=0, d2m_wpush=0.
- Accept: copy_start while !copy_busy latches src, dst and words into rd_addr/wr_addr/rd_rem/wr_rem/cp_rem; copy_busy=1 the next cycle. copy_start while busy is ignored.
- copy_words=0: no bursts; copy_done pulses 1 cycle after accept, then copy_busy drops.
- Burst sizing (each side, own address): beats = min(rem, MAX_BEATS, (4096 - addr[11:0])>>2). Bursts never cross a 4 KB boundary. LEN output = beats-1.
- Read FSM: R_IDLE -> R_ISSUE -> R_WAIT.
  - R_ISSUE: registers addr/len and pulses start_read for exactly 1 cycle; addr += beats*4, rd_rem -= beats.
  - R_WAIT: on done_read, goes to R_ISSUE if rd_rem>0, else R_IDLE.
- Copy path (combinational): m2d_rpull = d2m_wpush = busy & !m2d_rempty & !d2m_wfull & cp_rem>0; d2m_wdata = m2d_rdata. Each transfer decrements cp_rem and increments credit.
- Write FSM: W_IDLE -> W_ISSUE -> W_WAIT.
  - W_IDLE: moves to W_ISSUE when busy, wr_rem>0 and credit >= beats_w.
  - W_ISSUE: pulses start_write 1 cycle and registers addr/len; credit -= beats_w (same cycle as a copy increment, net applied); wr_addr/wr_rem update.
  - W_WAIT: on done_write, goes to W_IDLE. If wr_rem==0, pulses copy_done and clears copy_busy the following cycle.
- Credit width LEN_WIDTH+1; it never goes negative.
- Integration constraint: the d2m FIFO depth must be >= MAX_BEATS, otherwise deadlock can occur.
- done_read/done_write arriving outside the WAIT states are ignored.
- Read and write bursts may be outstanding simultaneously. Read and write burst counts may differ because src and dst have different 4 KB alignment.

Decomposition:
- Package axi_dma_pkg holds:
  - FSM state encodings (R_IDLE/R_ISSUE/R_WAIT, W_IDLE/W_ISSUE/W_WAIT)
  - constant PAGE_BYTES=4096
  - constant BYTES_PER_BEAT=DATA_WIDTH/8
- One sub-module axi_dma_burst_calc: pure combinational beats computation from (addr, rem), instantiated once for the read side and once for the write side.

Test Plan:
- src=0x1000, dst=0x2000, words=16, MAX_BEATS=16 -> one read burst (addr 0x1000, len 15), one write burst (addr 0x2000, len 15); data matches in order; copy_done one cycle after done_write.
- words=40 -> read lens 15, 15, 7 at 0x1000, 0x1040, 0x1080; write lens identical; copy_done once.
- src=0x1FF8, words=6 -> read bursts len 1 @0x1FF8 and len 3 @0x2000, no 4 KB crossing; dst=0x3000 gives one write of len 5.
- words=0 -> no start_read/start_write; copy_busy high 1 cycle; copy_done pulse.
- d2m_wfull held high 20 cycles mid-copy -> m2d_rpull=0 throughout, no start_write issued beyond available credit; copy completes correctly after release.
- rst_n asserted during R_WAIT -> all outputs 0 immediately; a new copy_start after reset runs cleanly; copy_start during busy produces no extra bursts.
